// File: rtl/fsmc_reg_bus_slave.sv
// FSMC asynchronous-bus slave: synchronises NE/NOE/NWE into clk, latches address and write data,
// issues single-cycle register-file strobes and drives read data onto the SB_IO pads.
module fsmc_reg_bus_slave #(
  parameter int unsigned ADRW        = 1,
  parameter int unsigned DATW        = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned CNTW        = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            aNE,
  input  logic            aNOE,
  input  logic            aNWE,
  input  logic [ADRW-1:0] aAn,
  input  logic [DATW-1:0] aDn,
  output logic [ADRW-1:0] rw_adr,
  output logic            do_write,
  output logic [DATW-1:0] w_data,
  output logic            do_read,
  input  logic [DATW-1:0] read_data,
  output logic            io_output,
  output logic [DATW-1:0] io_data,
  output logic            rd_abort,
  output logic            proto_err,
  output logic [CNTW-1:0] wr_count,
  output logic [CNTW-1:0] rd_count
);

  localparam int unsigned LATW = 4;

  typedef enum logic [3:0] {
    IDLE     = 4'b0001,
    WRITE    = 4'b0010,
    RD_WAIT  = 4'b0100,
    RD_DRIVE = 4'b1000
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] ne_sync;
  logic [SYNC_STAGES-1:0] noe_sync;
  logic [SYNC_STAGES-1:0] nwe_sync;
  logic [LATW-1:0]        wait_cnt;
  logic                   s_ne;
  logic                   s_noe;
  logic                   s_nwe;

  assign s_ne  = ne_sync[SYNC_STAGES-1];
  assign s_noe = noe_sync[SYNC_STAGES-1];
  assign s_nwe = nwe_sync[SYNC_STAGES-1];

  // Control-line synchronisers; reset to the idle (deasserted) level
  always_ff @(posedge clk) begin
    if (rst) begin
      ne_sync  <= '1;
      noe_sync <= '1;
      nwe_sync <= '1;
    end else begin
      ne_sync  <= {ne_sync[SYNC_STAGES-2:0], aNE};
      noe_sync <= {noe_sync[SYNC_STAGES-2:0], aNOE};
      nwe_sync <= {nwe_sync[SYNC_STAGES-2:0], aNWE};
    end
  end

  // Transaction FSM with registered strobes, latches and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      do_write  <= 1'b0;
      do_read   <= 1'b0;
      rd_abort  <= 1'b0;
      proto_err <= 1'b0;
      rw_adr    <= '0;
      w_data    <= '0;
      io_data   <= '0;
      wr_count  <= '0;
      rd_count  <= '0;
      wait_cnt  <= '0;
    end else begin
      do_write  <= 1'b0;
      do_read   <= 1'b0;
      rd_abort  <= 1'b0;
      proto_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!s_ne && !s_nwe && s_noe) begin
            state    <= WRITE;
            do_write <= 1'b1;
            rw_adr   <= aAn;
            w_data   <= aDn;
            wr_count <= wr_count + CNTW'(1);
          end else if (!s_ne && !s_noe && s_nwe) begin
            state    <= RD_WAIT;
            do_read  <= 1'b1;
            rw_adr   <= aAn;
            rd_count <= rd_count + CNTW'(1);
            wait_cnt <= LATW'(RD_LAT - 1);
          end else if (!s_ne && !s_noe && !s_nwe) begin
            proto_err <= 1'b1;
          end
        end
        WRITE: begin
          if (s_ne && s_nwe) state <= IDLE;
        end
        RD_WAIT: begin
          if (s_ne || s_noe) begin
            state    <= IDLE;
            rd_abort <= 1'b1;
          end else if (wait_cnt == '0) begin
            io_data <= read_data;
            state   <= RD_DRIVE;
          end else begin
            wait_cnt <= wait_cnt - LATW'(1);
          end
        end
        RD_DRIVE: begin
          if (s_ne || s_noe) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pads release in the same cycle the synchronised deassertion appears
  assign io_output = (state == RD_DRIVE) && !s_ne && !s_noe;

endmodule

// File: tb/tb_fsmc_reg_bus_slave.sv
// Scoreboard bench for fsmc_reg_bus_slave: bus-level transactions predict strobe/drive events,
// a monitor pops and compares them as the DUT produces them.
module tb_fsmc_reg_bus_slave;

  localparam int unsigned ADRW = 2;
  localparam int unsigned DATW = 8;
  localparam int unsigned S    = 2;
  localparam int unsigned LAT  = 3;
  localparam int unsigned CNTW = 4;
  localparam int          CMOD = 16;

  localparam int K_WR = 0;
  localparam int K_RD = 1;
  localparam int K_DV = 2;
  localparam int K_AB = 3;
  localparam int K_PE = 4;

  typedef struct {
    int kind;
    int adr;
    int data;
    int cnt;
    int dur;
  } ev_t;

  logic            clk;
  logic            rst;
  logic            aNE, aNOE, aNWE;
  logic [ADRW-1:0] aAn;
  logic [DATW-1:0] aDn;
  logic [ADRW-1:0] rw_adr;
  logic            do_write, do_read;
  logic [DATW-1:0] w_data;
  logic [DATW-1:0] read_data;
  logic            io_output;
  logic [DATW-1:0] io_data;
  logic            rd_abort, proto_err;
  logic [CNTW-1:0] wr_count, rd_count;

  ev_t exp_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;
  int  wr_n   = 0;
  int  rd_n   = 0;
  int  last_io = 0;

  fsmc_reg_bus_slave #(
    .ADRW(ADRW), .DATW(DATW), .SYNC_STAGES(S), .RD_LAT(LAT), .CNTW(CNTW)
  ) dut (
    .clk(clk), .rst(rst),
    .aNE(aNE), .aNOE(aNOE), .aNWE(aNWE),
    .aAn(aAn), .aDn(aDn),
    .rw_adr(rw_adr), .do_write(do_write), .w_data(w_data),
    .do_read(do_read), .read_data(read_data),
    .io_output(io_output), .io_data(io_data),
    .rd_abort(rd_abort), .proto_err(proto_err),
    .wr_count(wr_count), .rd_count(rd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic ev_t mk(input int kind, input int adr, input int data, input int cnt, input int dur);
    ev_t e;
    e.kind = kind; e.adr = adr; e.data = data; e.cnt = cnt; e.dur = dur;
    return e;
  endfunction

  task automatic idle_cycles(input int n);
    repeat (n) begin
      aNE = 1'b1; aNOE = 1'b1; aNWE = 1'b1;
      read_data = DATW'($urandom);
      step();
    end
  endtask

  // Write: strobe low for len clocks, exactly one do_write expected
  task automatic bus_write(input int adr, input int data, input int len);
    wr_n++;
    exp_q.push_back(mk(K_WR, adr, data, wr_n % CMOD, 0));
    for (int j = 0; j < len; j++) begin
      aNE = 1'b0; aNWE = 1'b0; aNOE = 1'b1;
      aAn = ADRW'(adr); aDn = DATW'(data);
      read_data = DATW'($urandom);
      step();
    end
  endtask

  // Read: NOE low for len clocks; read_data valid only at the edge RD_LAT after the strobe
  task automatic bus_read(input int adr, input int data, input int len);
    int span;
    rd_n++;
    exp_q.push_back(mk(K_RD, adr, 0, rd_n % CMOD, 0));
    if (len <= int'(LAT)) begin
      exp_q.push_back(mk(K_AB, 0, last_io, 0, 0));
    end else begin
      last_io = data;
      if (len - int'(LAT) - 1 > 0)
        exp_q.push_back(mk(K_DV, 0, data, 0, len - int'(LAT) - 1));
    end
    span = (len > int'(S + LAT) + 1) ? len : int'(S + LAT) + 1;
    for (int j = 0; j < span; j++) begin
      aNE = (j < len) ? 1'b0 : 1'b1;
      aNOE = (j < len) ? 1'b0 : 1'b1;
      aNWE = 1'b1;
      aAn = ADRW'(adr);
      read_data = (j == int'(S + LAT)) ? DATW'(data) : ~DATW'(data);
      step();
    end
  endtask

  task automatic bus_proto(input int n);
    exp_q.push_back(mk(K_PE, 0, 0, 0, n));
    for (int j = 0; j < n; j++) begin
      aNE = 1'b0; aNOE = 1'b0; aNWE = 1'b0;
      step();
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_do_write"}, 32'(do_write), 0);
    chk({tag, "_do_read"}, 32'(do_read), 0);
    chk({tag, "_rd_abort"}, 32'(rd_abort), 0);
    chk({tag, "_proto_err"}, 32'(proto_err), 0);
    chk({tag, "_io_output"}, 32'(io_output), 0);
    chk({tag, "_rw_adr"}, 32'(rw_adr), 0);
    chk({tag, "_w_data"}, 32'(w_data), 0);
    chk({tag, "_io_data"}, 32'(io_data), 0);
    chk({tag, "_wr_count"}, 32'(wr_count), 0);
    chk({tag, "_rd_count"}, 32'(rd_count), 0);
  endtask

  task automatic take(input int kind, input string nm, output ev_t e, output bit ok);
    ok = 1'b0;
    e = mk(-1, 0, 0, 0, 0);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_%s: got event with empty queue, required none at %0t", nm, $time);
    end else begin
      e = exp_q.pop_front();
      chk({nm, "_kind"}, 32'(kind), 32'(e.kind));
      ok = (e.kind == kind);
    end
  endtask

  // Monitor: pops one expected event per observed DUT event
  initial begin
    int   pe_run;
    int   dv_run;
    int   dv_data;
    ev_t  e;
    bit   ok;
    pe_run = 0;
    dv_run = 0;
    dv_data = 0;
    forever begin
      @(negedge clk);
      if (do_write === 1'b1) begin
        take(K_WR, "write", e, ok);
        if (ok) begin
          chk("write_adr", 32'(rw_adr), 32'(e.adr));
          chk("write_data", 32'(w_data), 32'(e.data));
          chk("write_count", 32'(wr_count), 32'(e.cnt));
        end
      end
      if (do_read === 1'b1) begin
        take(K_RD, "read", e, ok);
        if (ok) begin
          chk("read_adr", 32'(rw_adr), 32'(e.adr));
          chk("read_count", 32'(rd_count), 32'(e.cnt));
        end
      end
      if (rd_abort === 1'b1) begin
        take(K_AB, "abort", e, ok);
        if (ok) chk("abort_io_data", 32'(io_data), 32'(e.data));
      end
      if (proto_err === 1'b1) begin
        pe_run++;
      end else if (pe_run > 0) begin
        take(K_PE, "proto", e, ok);
        if (ok) chk("proto_cycles", 32'(pe_run), 32'(e.dur));
        pe_run = 0;
      end
      if (io_output === 1'b1) begin
        if (dv_run == 0) dv_data = int'(io_data);
        dv_run++;
      end else if (dv_run > 0) begin
        take(K_DV, "drive", e, ok);
        if (ok) begin
          chk("drive_data", 32'(dv_data), 32'(e.data));
          chk("drive_cycles", 32'(dv_run), 32'(e.dur));
        end
        dv_run = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int kind;
    rst = 1'b1;
    aNE = 1'b1; aNOE = 1'b1; aNWE = 1'b1;
    aAn = '0; aDn = '0; read_data = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    idle_cycles(3);

    // Directed: plain write, read, abort, protocol error
    bus_write(2, 8'hA5, 6);
    idle_cycles(2);
    bus_read(1, 8'h3C, 12);
    idle_cycles(2);
    bus_read(3, 8'h77, 2);
    idle_cycles(1);
    bus_write(1, 8'h5A, 4);
    idle_cycles(1);
    bus_proto(3);
    idle_cycles(2);

    // Back-to-back writes past the counter wrap, plus one held-low strobe
    for (int i = 0; i < 17; i++) begin
      bus_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), 3);
      idle_cycles(1);
    end
    bus_write(0, 8'h11, 30);
    idle_cycles(2);
    chk("wrap_wr_count", 32'(wr_count), 32'(wr_n % CMOD));

    // Randomised mix
    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 9));
      if (kind <= 3)
        bus_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                  (kind == 0) ? int'($urandom_range(10, 25)) : int'($urandom_range(3, 8)));
      else if (kind <= 6)
        bus_read(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                 int'($urandom_range(LAT + 1, LAT + 8)));
      else if (kind == 7)
        bus_read(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                 int'($urandom_range(1, LAT)));
      else
        bus_proto(int'($urandom_range(1, 4)));
      idle_cycles(int'($urandom_range(1, 3)));
    end
    chk("final_wr_count", 32'(wr_count), 32'(wr_n % CMOD));
    chk("final_rd_count", 32'(rd_count), 32'(rd_n % CMOD));

    // Reset while driving, NOE still low afterwards: a fresh read follows
    rd_n++;
    exp_q.push_back(mk(K_RD, 2, 0, rd_n % CMOD, 0));
    exp_q.push_back(mk(K_DV, 0, 8'h3C, 0, 3));
    for (int j = 0; j < 20; j++) begin
      aNE = 1'b0; aNOE = 1'b0; aNWE = 1'b1; aAn = 2'd2;
      rst = (j == int'(S + LAT) + 3) ? 1'b1 : 1'b0;
      if (j == int'(S + LAT)) read_data = 8'h3C;
      else if (j == int'(S + LAT) + 4 + int'(S + LAT)) read_data = 8'hC3;
      else read_data = 8'h00;
      step();
      if (j == int'(S + LAT) + 3) begin
        check_all_zero("midreset");
        wr_n = 0;
        rd_n = 1;
        last_io = 8'hC3;
        exp_q.push_back(mk(K_RD, 2, 0, 1, 0));
        exp_q.push_back(mk(K_DV, 0, 8'hC3, 0, 20 - (int'(S + LAT) + 4) - int'(LAT) - 1));
      end
    end
    rst = 1'b0;
    idle_cycles(4);
    bus_write(3, 8'hE7, 5);
    idle_cycles(10);
    chk("post_reset_rd_count", 32'(rd_count), 32'(rd_n % CMOD));
    chk("post_reset_wr_count", 32'(wr_count), 32'(wr_n % CMOD));
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
